// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: state encoding
// and default widths/limits.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data ports onto one single-port memory. Data wins
// by default; a fetch that has lost STARVE_LIMIT consecutive decisions wins next.
//
// state | meaning
// IDLE  | no transaction open; grant decision taken this cycle
// GNT_I | fetch command presented to memory, waiting for mem_ack
// GNT_D | data command presented to memory, waiting for mem_ack
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_i;
    logic             grant_d;

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !(if_req && starve_cnt == CNT_MAX)) begin
                    grant_d   = 1'b1;
                    state_nxt = GNT_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stray acks in IDLE fall through: neither ready term can fire there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state    <= state_nxt;
            if_ready <= (state == GNT_I) && mem_ack;
            d_ready  <= (state == GNT_D) && mem_ack;
            if ((state == GNT_I) && mem_ack) if_rdata <= mem_rdata;
            if ((state == GNT_D) && mem_ack) d_rdata  <= mem_rdata;

            if (grant_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_i) begin
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end

            if (!if_req || grant_i)
                starve_cnt <= '0;
            else if (grant_d && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign mem_req = (state != IDLE);

endmodule
